// File: rtl/player_instr_arbiter_pkg.sv
// Shared game definitions used by the player instruction arbiter.
//  - op_e      : player datapath opcodes (upper nibble of an instruction word)
//  - dir_e     : movement directions carried in the MOV argument
//  - arb_state_e : arbiter bus state (IDLE = nothing offered, HOLD = instr valid)
//  - make_instr  : packs {op[3:0], arg[7:0], 4'b0000}
//  - instr_op    : extracts the opcode field of an instruction word
package player_instr_arbiter_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_HPY = 4'h1,
      OP_DPY = 4'h2,
      OP_IDG = 4'h3,
      OP_SDG = 4'h4,
      OP_MOV = 4'h5,
      OP_SHP = 4'h6
   } op_e;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_e;

   function automatic logic [15:0] make_instr(input op_e op, input logic [7:0] arg);
      return {op, arg, 4'b0000};
   endfunction

   function automatic logic [3:0] instr_op(input logic [15:0] instr);
      return instr[15:12];
   endfunction

endpackage

// File: rtl/player_instr_arbiter_fifo.sv
// Damage-event queue: synchronous FIFO with occupancy count.
// Ports:
//  clk, rst   clock and asynchronous active-high reset
//  clr_i      synchronous flush (empties the queue next edge)
//  push_i     write din_i; taken when not full, or when full and popping
//  pop_i      drop the head entry (ignored when empty)
//  din_i      write data
//  dout_o     head entry (valid while !empty_o)
//  count_o    number of queued entries, 0..DEPTH
//  full_o, empty_o  occupancy flags
module player_instr_arbiter_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      full_o   = (count_q == (AW+1)'(DEPTH));
      empty_o  = (count_q == '0);
      do_pop   = pop_i && !empty_o && !clr_i;
      // When full, a same-cycle pop frees the slot the push writes into.
      do_push  = push_i && (!full_o || do_pop) && !clr_i;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/player_instr_arbiter.sv
// Player instruction arbiter for the DODGE page. Merges heal, damage and move
// requests onto one 16-bit valid/ready instruction bus with priority
// HPY > DPY > MOV, and runs the post-hit invulnerability window.
// Ports:
//  clk, rst                 clock, asynchronous active-high reset
//  enable                   page is DODGE; low flushes all pending work
//  mv_req/mv_dir            move pulse and direction (latest wins)
//  dmg_req/dmg_amt          damage pulse and amount (queued)
//  heal_req/heal_amt        heal pulse and amount (accumulated, saturating)
//  instr/instr_valid        offered instruction {op, arg, 4'b0}
//  instr_ready              datapath accepts instr this cycle
//  invuln                   invulnerability window active
//  dmg_dropped              one-cycle pulse after a discarded damage request
//  fifo_level               damage entries queued
module player_instr_arbiter
   import player_instr_arbiter_pkg::*;
#(
   parameter int         FIFO_DEPTH    = 4,
   parameter int         INVULN_CYCLES = 25_000_000,
   parameter logic [7:0] HEAL_MAX      = 8'd255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         mv_req,
   input  logic [1:0]                   mv_dir,
   input  logic                         dmg_req,
   input  logic [7:0]                   dmg_amt,
   input  logic                         heal_req,
   input  logic [7:0]                   heal_amt,
   output logic [15:0]                  instr,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic                         invuln,
   output logic                         dmg_dropped,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
   localparam int CW = (INVULN_CYCLES > 2) ? $clog2(INVULN_CYCLES) : 1;

   arb_state_e  state_q, state_d;
   logic [15:0] instr_q, instr_d;
   logic [7:0]  heal_acc_q, heal_acc_d;
   logic        mv_pend_q, mv_pend_d;
   logic [1:0]  mv_dir_q, mv_dir_d;
   logic [CW-1:0] inv_cnt_q, inv_cnt_d;
   logic        dmg_dropped_q, dmg_dropped_d;

   logic        slot_free, dpy_xfer, invuln_w;
   logic        heal_in, dmg_in, mv_in;
   logic        heal_avail, sel_heal, sel_dmg_fifo, sel_dmg_byp, sel_mv, dmg_ok;
   logic [7:0]  heal_arg, heal_base;
   logic [8:0]  heal_sum;
   logic [1:0]  mv_arg_dir;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_head;

   // Request capture and source selection. Same-cycle requests can bypass
   // their holding register so an idle bus answers in one cycle.
   always_comb begin
      slot_free    = (state_q == ST_IDLE) || instr_ready;
      dpy_xfer     = (state_q == ST_HOLD) && instr_ready && (instr_op(instr_q) == OP_DPY);
      // The window is already active in the cycle the hit is accepted.
      invuln_w     = (inv_cnt_q != '0) || dpy_xfer;

      heal_in      = enable && heal_req && (heal_amt != 8'd0);
      dmg_in       = enable && dmg_req && (dmg_amt != 8'd0);
      mv_in        = enable && mv_req;

      heal_avail   = (heal_acc_q != 8'd0) || heal_in;
      heal_arg     = (heal_acc_q != 8'd0) ? heal_acc_q : heal_amt;
      sel_heal     = enable && slot_free && heal_avail;
      sel_dmg_fifo = enable && slot_free && !heal_avail && !fifo_empty;
      dmg_ok       = dmg_in && !invuln_w && (!fifo_full || sel_dmg_fifo);
      sel_dmg_byp  = enable && slot_free && !heal_avail && fifo_empty && dmg_ok;
      mv_arg_dir   = mv_in ? mv_dir : mv_dir_q;
      sel_mv       = enable && slot_free && !heal_avail && fifo_empty && !dmg_ok
                     && (mv_pend_q || mv_in);

      fifo_push     = dmg_ok && !sel_dmg_byp;
      fifo_pop      = sel_dmg_fifo;
      dmg_dropped_d = dmg_in && !dmg_ok;

      // Heal accumulator: when the stored total is issued, a coincident heal
      // starts a fresh total; a bypassed heal is consumed outright.
      heal_base  = (sel_heal && (heal_acc_q != 8'd0)) ? 8'd0 : heal_acc_q;
      heal_sum   = {1'b0, heal_base} + {1'b0, heal_amt};
      heal_acc_d = heal_base;
      if (!enable) begin
         heal_acc_d = 8'd0;
      end else if (sel_heal && (heal_acc_q == 8'd0)) begin
         heal_acc_d = 8'd0;
      end else if (heal_in) begin
         heal_acc_d = (heal_sum > {1'b0, HEAL_MAX}) ? HEAL_MAX : heal_sum[7:0];
      end

      mv_pend_d = mv_pend_q;
      mv_dir_d  = mv_dir_q;
      if (!enable || sel_mv) begin
         mv_pend_d = 1'b0;
      end else if (mv_in) begin
         mv_pend_d = 1'b1;
         mv_dir_d  = mv_dir;
      end

      inv_cnt_d = inv_cnt_q;
      if (dpy_xfer)                inv_cnt_d = CW'(INVULN_CYCLES - 1);
      else if (inv_cnt_q != '0)    inv_cnt_d = inv_cnt_q - 1'b1;
   end

   // Bus FSM: next state and next instruction word.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      if (!enable) begin
         state_d = ST_IDLE;
         instr_d = '0;
      end else if (slot_free) begin
         state_d = ST_HOLD;
         if (sel_heal)          instr_d = make_instr(OP_HPY, heal_arg);
         else if (sel_dmg_fifo) instr_d = make_instr(OP_DPY, fifo_head);
         else if (sel_dmg_byp)  instr_d = make_instr(OP_DPY, dmg_amt);
         else if (sel_mv)       instr_d = make_instr(OP_MOV, {6'b0, mv_arg_dir});
         else begin
            state_d = ST_IDLE;
            instr_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         instr_q       <= '0;
         heal_acc_q    <= '0;
         mv_pend_q     <= 1'b0;
         mv_dir_q      <= '0;
         inv_cnt_q     <= '0;
         dmg_dropped_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         heal_acc_q    <= heal_acc_d;
         mv_pend_q     <= mv_pend_d;
         mv_dir_q      <= mv_dir_d;
         inv_cnt_q     <= inv_cnt_d;
         dmg_dropped_q <= dmg_dropped_d;
      end
   end

   player_instr_arbiter_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_dmg_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (!enable),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (dmg_amt),
      .dout_o  (fifo_head),
      .count_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign instr       = instr_q;
   assign instr_valid = (state_q == ST_HOLD);
   assign invuln      = invuln_w;
   assign dmg_dropped = dmg_dropped_q;

endmodule
